// File: rtl/uart_cmd_ctrl.sv
// Command sequencer between the UART receive path and the ADC sampling logic.
// Parses 5-byte frames (HDR, CMD, ARG_H, ARG_L, CSUM), checks the XOR checksum,
// updates the ADC configuration registers and reports each frame outcome as a
// single ACK/NAK pulse plus a held error code.
//
// Receive handshake: rx_valid is a one-cycle strobe qualifying rx_byte; there is
// no back-pressure, so a byte is consumed (or deliberately dropped) on the edge
// where rx_valid is high. rx_err on the same edge overrides rx_valid and the
// byte is discarded.
module uart_cmd_ctrl #(
  parameter logic [7:0]  HDR         = 8'hAA,
  parameter int          TIMEOUT_CYC = 50000,
  parameter logic [15:0] DIV_DEFAULT = 16'd1000,
  parameter int          CHAN_W      = 3,
  parameter int          CHAN_MAX    = 7
) (
  input  logic              RST_clk,
  input  logic              RST_n,
  input  logic [7:0]        rx_byte,
  input  logic              rx_valid,
  input  logic              rx_err,
  output logic              adc_en,
  output logic [CHAN_W-1:0] adc_chan,
  output logic [15:0]       adc_div,
  output logic              cmd_ack,
  output logic              cmd_nak,
  output logic [2:0]        err_code,
  output logic              busy,
  output logic [2:0]        dbg_state
);

  localparam int              CNT_W      = $clog2(TIMEOUT_CYC);
  localparam logic [CNT_W-1:0] CNT_TERM  = CNT_W'(TIMEOUT_CYC - 1);
  localparam logic [15:0]     CHAN_LIMIT = 16'(CHAN_MAX);

  localparam logic [2:0] E_OK      = 3'd0;
  localparam logic [2:0] E_CSUM    = 3'd1;
  localparam logic [2:0] E_CMD     = 3'd2;
  localparam logic [2:0] E_ARG     = 3'd3;
  localparam logic [2:0] E_FRAMING = 3'd4;
  localparam logic [2:0] E_TIMEOUT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_GET_CMD = 3'd1,
    S_GET_AH  = 3'd2,
    S_GET_AL  = 3'd3,
    S_GET_CS  = 3'd4,
    S_EXEC    = 3'd5
  } state_e;

  state_e            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [7:0]        cmd_q, ah_q, al_q, cs_q;
  logic              adc_en_q;
  logic [CHAN_W-1:0] adc_chan_q;
  logic [15:0]       adc_div_q;
  logic              ack_q, nak_q;
  logic [2:0]        err_q;

  logic              ok_d;
  logic [2:0]        code_d;
  logic              adc_en_d;
  logic [CHAN_W-1:0] adc_chan_d;
  logic [15:0]       adc_div_d;
  logic [15:0]       arg;

  assign arg = {ah_q, al_q};

  // Decode the latched frame: checksum first, then command and argument range.
  always_comb begin
    ok_d       = 1'b1;
    code_d     = E_OK;
    adc_en_d   = adc_en_q;
    adc_chan_d = adc_chan_q;
    adc_div_d  = adc_div_q;
    if ((cmd_q ^ ah_q ^ al_q) != cs_q) begin
      ok_d   = 1'b0;
      code_d = E_CSUM;
    end else begin
      case (cmd_q)
        8'h01: adc_en_d = 1'b1;
        8'h02: adc_en_d = 1'b0;
        8'h03: begin
          if (arg == 16'd0) begin
            ok_d   = 1'b0;
            code_d = E_ARG;
          end else begin
            adc_div_d = arg;
          end
        end
        8'h04: begin
          if (arg > CHAN_LIMIT) begin
            ok_d   = 1'b0;
            code_d = E_ARG;
          end else begin
            adc_chan_d = arg[CHAN_W-1:0];
          end
        end
        8'h05: begin
          adc_en_d   = 1'b0;
          adc_chan_d = '0;
          adc_div_d  = DIV_DEFAULT;
        end
        default: begin
          ok_d   = 1'b0;
          code_d = E_CMD;
        end
      endcase
    end
  end

  // Frame FSM with byte latches, idle timeout and registered outcome outputs.
  always_ff @(posedge RST_clk or negedge RST_n) begin
    if (!RST_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      cmd_q      <= '0;
      ah_q       <= '0;
      al_q       <= '0;
      cs_q       <= '0;
      adc_en_q   <= 1'b0;
      adc_chan_q <= '0;
      adc_div_q  <= DIV_DEFAULT;
      ack_q      <= 1'b0;
      nak_q      <= 1'b0;
      err_q      <= E_OK;
    end else begin
      ack_q <= 1'b0;
      nak_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          cnt_q <= '0;
          if (rx_valid && !rx_err && rx_byte == HDR) state_q <= S_GET_CMD;
        end
        S_GET_CMD, S_GET_AH, S_GET_AL, S_GET_CS: begin
          if (rx_err) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nak_q   <= 1'b1;
            err_q   <= E_FRAMING;
          end else if (rx_valid) begin
            // A byte on the terminal-count cycle still wins over the timeout.
            cnt_q <= '0;
            case (state_q)
              S_GET_CMD: begin cmd_q <= rx_byte; state_q <= S_GET_AH; end
              S_GET_AH:  begin ah_q  <= rx_byte; state_q <= S_GET_AL; end
              S_GET_AL:  begin al_q  <= rx_byte; state_q <= S_GET_CS; end
              default:   begin cs_q  <= rx_byte; state_q <= S_EXEC;   end
            endcase
          end else if (cnt_q == CNT_TERM) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            nak_q   <= 1'b1;
            err_q   <= E_TIMEOUT;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        S_EXEC: begin
          // Receive strobes during this single cycle are intentionally dropped.
          state_q    <= S_IDLE;
          cnt_q      <= '0;
          adc_en_q   <= adc_en_d;
          adc_chan_q <= adc_chan_d;
          adc_div_q  <= adc_div_d;
          ack_q      <= ok_d;
          nak_q      <= !ok_d;
          err_q      <= code_d;
        end
        default: begin
          state_q <= S_IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign adc_en    = adc_en_q;
  assign adc_chan  = adc_chan_q;
  assign adc_div   = adc_div_q;
  assign cmd_ack   = ack_q;
  assign cmd_nak   = nak_q;
  assign err_code  = err_q;
  assign busy      = (state_q != S_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_uart_cmd_ctrl.sv
// Directed bench for uart_cmd_ctrl: a frame-level reference model tracks the
// received byte stream and predicts every output each cycle; directed checks
// pin key literal values along the way.
module tb_uart_cmd_ctrl;

  localparam int         T        = 20;
  localparam logic [7:0] HDR      = 8'hAA;
  localparam int         DIVD     = 1000;
  localparam int         CHAN_MAX = 7;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [7:0] rx_byte = 8'h00;
  logic       rx_valid = 1'b0;
  logic       rx_err = 1'b0;

  logic       adc_en;
  logic [2:0] adc_chan;
  logic [15:0] adc_div;
  logic       cmd_ack, cmd_nak, busy;
  logic [2:0] err_code;
  logic [2:0] dbg_state;

  always #5 clk = ~clk;

  uart_cmd_ctrl #(
    .HDR(HDR), .TIMEOUT_CYC(T), .DIV_DEFAULT(16'd1000), .CHAN_W(3), .CHAN_MAX(CHAN_MAX)
  ) dut (
    .RST_clk(clk), .RST_n(rst_n), .rx_byte(rx_byte), .rx_valid(rx_valid), .rx_err(rx_err),
    .adc_en(adc_en), .adc_chan(adc_chan), .adc_div(adc_div), .cmd_ack(cmd_ack),
    .cmd_nak(cmd_nak), .err_code(err_code), .busy(busy), .dbg_state(dbg_state)
  );

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  logic [7:0] m_frame[$];
  int   m_idle = 0;
  bit   m_pend = 0;
  logic m_en = 0;
  int   m_chan = 0;
  int   m_div = DIVD;
  int   m_err = 0;
  logic m_ack = 0;
  logic m_nak = 0;

  task automatic model_reject(input int code);
    m_nak = 1'b1;
    m_err = code;
  endtask

  task automatic model_exec();
    logic [7:0] c, h, l, s;
    int arg;
    c = m_frame[1]; h = m_frame[2]; l = m_frame[3]; s = m_frame[4];
    arg = int'(h) * 256 + int'(l);
    if ((c ^ h ^ l) != s) model_reject(1);
    else if (c == 8'h01) begin m_en = 1'b1; m_ack = 1'b1; m_err = 0; end
    else if (c == 8'h02) begin m_en = 1'b0; m_ack = 1'b1; m_err = 0; end
    else if (c == 8'h03) begin
      if (arg == 0) model_reject(3);
      else begin m_div = arg; m_ack = 1'b1; m_err = 0; end
    end
    else if (c == 8'h04) begin
      if (arg > CHAN_MAX) model_reject(3);
      else begin m_chan = arg; m_ack = 1'b1; m_err = 0; end
    end
    else if (c == 8'h05) begin
      m_en = 1'b0; m_chan = 0; m_div = DIVD; m_ack = 1'b1; m_err = 0;
    end
    else model_reject(2);
  endtask

  // Model advances on the same edges the DUT samples its inputs.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_frame.delete();
      m_idle = 0; m_pend = 0;
      m_en = 0; m_chan = 0; m_div = DIVD; m_err = 0;
      m_ack = 0; m_nak = 0;
    end else begin
      m_ack = 0;
      m_nak = 0;
      if (m_pend) begin
        model_exec();
        m_pend = 0;
        m_frame.delete();
      end else if (m_frame.size() == 0) begin
        if (rx_valid && !rx_err && rx_byte == HDR) m_frame.push_back(rx_byte);
        m_idle = 0;
      end else if (rx_err) begin
        model_reject(4);
        m_frame.delete();
      end else if (rx_valid) begin
        m_frame.push_back(rx_byte);
        m_idle = 0;
        if (m_frame.size() == 5) m_pend = 1;
      end else if (m_idle == T - 1) begin
        model_reject(5);
        m_frame.delete();
      end else begin
        m_idle++;
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("adc_en",   32'(adc_en),   32'(m_en));
    check("adc_chan", 32'(adc_chan), 32'(m_chan));
    check("adc_div",  32'(adc_div),  32'(m_div));
    check("cmd_ack",  32'(cmd_ack),  32'(m_ack));
    check("cmd_nak",  32'(cmd_nak),  32'(m_nak));
    check("err_code", 32'(err_code), 32'(m_err));
    check("busy",     32'(busy),     32'((m_frame.size() != 0) || m_pend));
  end

  // ---------------- drivers (called at a negedge) ----------------
  task automatic drive_byte(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1; rx_err = 1'b0;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic drive_err_byte(input logic [7:0] b);
    rx_byte = b; rx_valid = 1'b1; rx_err = 1'b1;
    @(negedge clk);
    rx_valid = 1'b0; rx_err = 1'b0;
  endtask

  task automatic send_frame(input logic [7:0] c, input logic [7:0] h,
                            input logic [7:0] l, input logic [7:0] s);
    drive_byte(HDR); drive_byte(c); drive_byte(h); drive_byte(l); drive_byte(s);
  endtask

  // Sends a frame and returns in the cycle where the outcome pulse is visible.
  task automatic frame_and_wait(input logic [7:0] c, input logic [7:0] h,
                                input logic [7:0] l, input logic [7:0] s);
    send_frame(c, h, l, s);
    @(negedge clk);
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    #1 rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_adc_en", 32'(adc_en), 0);
    check("rst_adc_chan", 32'(adc_chan), 0);
    check("rst_adc_div", 32'(adc_div), 1000);
    check("rst_err", 32'(err_code), 0);
    check("rst_busy", 32'(busy), 0);
    check("rst_pulses", 32'({cmd_ack, cmd_nak}), 0);
    rst_n = 1'b1;

    // START: pulse arrives one cycle after the CSUM byte
    send_frame(8'h01, 8'h00, 8'h00, 8'h01);
    check("start_exec_busy", 32'(busy), 1);
    check("start_no_early_ack", 32'(cmd_ack), 0);
    @(negedge clk);
    check("start_ack", 32'(cmd_ack), 1);
    check("start_en", 32'(adc_en), 1);
    check("start_busy", 32'(busy), 0);
    @(negedge clk);
    check("start_ack_1cyc", 32'(cmd_ack), 0);

    // SET_DIV good, then zero argument
    frame_and_wait(8'h03, 8'h12, 8'h34, 8'h25);
    check("div_ack", 32'(cmd_ack), 1);
    check("div_val", 32'(adc_div), 32'h1234);
    frame_and_wait(8'h03, 8'h00, 8'h00, 8'h03);
    check("div0_nak", 32'(cmd_nak), 1);
    check("div0_code", 32'(err_code), 3);
    check("div0_keep", 32'(adc_div), 32'h1234);

    // SET_CHAN out of range, in range, unknown command
    frame_and_wait(8'h04, 8'h00, 8'h09, 8'h0D);
    check("chan9_nak", 32'(cmd_nak), 1);
    check("chan9_code", 32'(err_code), 3);
    check("chan9_keep", 32'(adc_chan), 0);
    frame_and_wait(8'h04, 8'h00, 8'h05, 8'h01);
    check("chan5_ack", 32'(cmd_ack), 1);
    check("chan5_val", 32'(adc_chan), 5);
    frame_and_wait(8'h7F, 8'h00, 8'h00, 8'h7F);
    check("unk_nak", 32'(cmd_nak), 1);
    check("unk_code", 32'(err_code), 2);

    // Bad checksum, then stray bytes in IDLE
    frame_and_wait(8'h01, 8'h00, 8'h00, 8'h00);
    check("csum_nak", 32'(cmd_nak), 1);
    check("csum_code", 32'(err_code), 1);
    check("csum_en_keep", 32'(adc_en), 1);
    drive_byte(8'h55);
    drive_byte(8'h00);
    check("stray_busy", 32'(busy), 0);
    check("stray_pulses", 32'({cmd_ack, cmd_nak}), 0);

    // HDR value inside a frame is plain data
    frame_and_wait(8'h02, 8'hAA, 8'hAA, 8'h02);
    check("hdr_data_ack", 32'(cmd_ack), 1);
    check("hdr_data_en", 32'(adc_en), 0);

    // A byte arriving during EXEC is dropped
    send_frame(8'h01, 8'h00, 8'h00, 8'h01);
    drive_byte(HDR);
    check("exec_drop_ack", 32'(cmd_ack), 1);
    check("exec_drop_busy", 32'(busy), 0);

    // SOFT_RST
    frame_and_wait(8'h05, 8'h00, 8'h00, 8'h05);
    check("srst_ack", 32'(cmd_ack), 1);
    check("srst_en", 32'(adc_en), 0);
    check("srst_chan", 32'(adc_chan), 0);
    check("srst_div", 32'(adc_div), 1000);

    // HDR together with rx_err in IDLE is ignored
    drive_err_byte(HDR);
    check("idle_err_busy", 32'(busy), 0);
    check("idle_err_nak", 32'(cmd_nak), 0);

    // Timeout after AA 01 and T idle clocks
    drive_byte(HDR); drive_byte(8'h01);
    repeat (T - 1) @(negedge clk);
    check("to_not_yet", 32'(cmd_nak), 0);
    check("to_busy_before", 32'(busy), 1);
    @(negedge clk);
    check("to_nak", 32'(cmd_nak), 1);
    check("to_code", 32'(err_code), 5);
    check("to_busy", 32'(busy), 0);
    @(negedge clk);
    check("to_single", 32'(cmd_nak), 0);

    // rx_err on the ARG_H byte: NAK on the same edge that samples it
    drive_byte(HDR); drive_byte(8'h03);
    drive_err_byte(8'h12);
    check("rxerr_nak", 32'(cmd_nak), 1);
    check("rxerr_code", 32'(err_code), 4);
    check("rxerr_busy", 32'(busy), 0);

    // Byte on the terminal-count cycle is accepted
    drive_byte(HDR); drive_byte(8'h01);
    repeat (T - 1) @(negedge clk);
    drive_byte(8'h00);
    check("term_busy", 32'(busy), 1);
    check("term_no_nak", 32'(cmd_nak), 0);
    drive_byte(8'h00); drive_byte(8'h01);
    @(negedge clk);
    check("term_ack", 32'(cmd_ack), 1);
    check("term_en", 32'(adc_en), 1);

    // Reset mid-frame
    frame_and_wait(8'h03, 8'h12, 8'h34, 8'h25);
    frame_and_wait(8'h7F, 8'h00, 8'h00, 8'h7F);
    drive_byte(HDR); drive_byte(8'h03); drive_byte(8'h12);
    #2 rst_n = 1'b0;
    #1;
    check("mid_rst_en", 32'(adc_en), 0);
    check("mid_rst_div", 32'(adc_div), 1000);
    check("mid_rst_err", 32'(err_code), 0);
    check("mid_rst_busy", 32'(busy), 0);
    check("mid_rst_pulses", 32'({cmd_ack, cmd_nak}), 0);
    repeat (2) @(negedge clk);
    #2 rst_n = 1'b1;
    @(negedge clk);
    frame_and_wait(8'h04, 8'h00, 8'h03, 8'h07);
    check("post_rst_ack", 32'(cmd_ack), 1);
    check("post_rst_chan", 32'(adc_chan), 3);

    repeat (3) @(negedge clk);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
